latch_resp_checker: RTL and testbench

//  Synthesizable response checker for the level-sensitive D-latch cells (negative- or positive-enable).

---
 rtl/latch_resp_checker.sv | 107 ++++++++++
 tb/tb_latch_resp_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/latch_resp_checker.sv
// Response checker for a level-sensitive D latch: runs a cycle model of the latch,
// compares the observed q SETTLE_CYC cycles after each stimulus sample, and keeps stats.
module latch_resp_checker #(
    parameter bit EN_ACTIVE_LOW = 1'b1,
    parameter int SETTLE_CYC    = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             d_in,
    input  logic             en_in,
    input  logic             q_in,
    output logic             busy_out,
    output logic             err_out,
    output logic             fail_out,
    output logic [CNT_W-1:0] chk_cnt_out,
    output logic [CNT_W-1:0] err_cnt_out,
    output logic [CNT_W-1:0] first_err_out
);
    typedef enum logic [1:0] {IDLE, ARM, CHECK} state_t;

    state_t                state;
    logic                  model_q;
    logic [SETTLE_CYC-1:0] line;
    logic [SETTLE_CYC-1:0] line_shift;
    logic [3:0]            settle_cnt;
    logic                  en_act;
    logic                  exp_now;
    logic                  exp_init;
    logic                  exp_d;
    logic                  mismatch;

    assign en_act   = EN_ACTIVE_LOW ? ~en_in : en_in;
    assign exp_now  = en_act ? d_in : model_q;
    // DUT power-up state is unknown, so an opaque latch is seeded from what it shows
    assign exp_init = en_act ? d_in : q_in;
    assign exp_d    = line[SETTLE_CYC-1];
    assign mismatch = (q_in != exp_d);

    // line[0] is the newest expectation, line[SETTLE_CYC-1] the one due for comparison
    always_comb begin
        line_shift    = line << 1;
        line_shift[0] = exp_now;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            busy_out      <= 1'b0;
            err_out       <= 1'b0;
            fail_out      <= 1'b0;
            chk_cnt_out   <= '0;
            err_cnt_out   <= '0;
            first_err_out <= '0;
            model_q       <= 1'b0;
            line          <= '0;
            settle_cnt    <= '0;
        end else begin
            err_out <= 1'b0;
            if (start_in) begin
                state         <= ARM;
                busy_out      <= 1'b1;
                fail_out      <= 1'b0;
                chk_cnt_out   <= '0;
                err_cnt_out   <= '0;
                first_err_out <= '0;
                settle_cnt    <= '0;
            end else if (stop_in && state != IDLE) begin
                state    <= IDLE;
                busy_out <= 1'b0;
            end else begin
                case (state)
                    ARM: begin
                        if (settle_cnt == 4'd0) begin
                            model_q <= exp_init;
                            line    <= {SETTLE_CYC{exp_init}};
                        end else begin
                            model_q <= exp_now;
                            line    <= line_shift;
                        end
                        if (settle_cnt == 4'(SETTLE_CYC - 1))
                            state <= CHECK;
                        else
                            settle_cnt <= settle_cnt + 4'd1;
                    end
                    CHECK: begin
                        model_q <= exp_now;
                        line    <= line_shift;
                        if (~&chk_cnt_out)
                            chk_cnt_out <= chk_cnt_out + CNT_W'(1);
                        if (mismatch) begin
                            err_out  <= 1'b1;
                            fail_out <= 1'b1;
                            if (~&err_cnt_out)
                                err_cnt_out <= err_cnt_out + CNT_W'(1);
                            if (!fail_out)
                                first_err_out <= chk_cnt_out;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_latch_resp_checker.sv
// Directed bench for latch_resp_checker: three checker instances (nls default, pls, 4-bit
// counters) watch a behavioural nls latch whose q is delayed by the settle time.
module tb_latch_resp_checker;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_in = 1'b1, start_in = 1'b0, stop_in = 1'b0, d = 1'b0, en = 1'b0;
    logic q_drv;
    int   q_mode = 0;  // 0 ideal, 1 stuck-at-0, 2 inverted
    int   nvec = 0, nerr = 0;

    logic a_busy, a_err, a_fail;  logic [15:0] a_chk, a_errc, a_first;
    logic p_busy, p_err, p_fail;  logic [15:0] p_chk, p_errc, p_first;
    logic c_busy, c_err, c_fail;  logic [3:0]  c_chk, c_errc, c_first;

    always #5 clk = ~clk;

    // nls latch seen through an S-cycle response delay
    logic         lat_now;
    logic         lat_q = 1'b0;
    logic [S-1:0] qp = '0;
    always_comb lat_now = en ? lat_q : d;
    always @(posedge clk) begin
        lat_q <= lat_now;
        qp    <= {qp[S-2:0], lat_now};
    end
    always_comb q_drv = (q_mode == 0) ? qp[S-1] : (q_mode == 1) ? 1'b0 : ~qp[S-1];

    latch_resp_checker #(.EN_ACTIVE_LOW(1'b1), .SETTLE_CYC(S), .CNT_W(16)) u_dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
        .d_in(d), .en_in(en), .q_in(q_drv), .busy_out(a_busy), .err_out(a_err),
        .fail_out(a_fail), .chk_cnt_out(a_chk), .err_cnt_out(a_errc), .first_err_out(a_first));

    latch_resp_checker #(.EN_ACTIVE_LOW(1'b0), .SETTLE_CYC(S), .CNT_W(16)) u_pls (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
        .d_in(d), .en_in(en), .q_in(q_drv), .busy_out(p_busy), .err_out(p_err),
        .fail_out(p_fail), .chk_cnt_out(p_chk), .err_cnt_out(p_errc), .first_err_out(p_first));

    latch_resp_checker #(.EN_ACTIVE_LOW(1'b1), .SETTLE_CYC(S), .CNT_W(4)) u_c4 (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
        .d_in(d), .en_in(en), .q_in(q_drv), .busy_out(c_busy), .err_out(c_err),
        .fail_out(c_fail), .chk_cnt_out(c_chk), .err_cnt_out(c_errc), .first_err_out(c_first));

    task automatic drive(input int k, input bit st, input bit sp);
        d        = 1'((k / 6) % 2);
        en       = 1'((k / 10) % 2);
        start_in = st;
        stop_in  = sp;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        d = 1'b0; en = 1'b0; start_in = 1'b0; stop_in = 1'b0; rst_in = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %0d want 0", a_busy); end
        nvec++; if (a_err !== 1'b0) begin nerr++; $display("FAIL rst_err got %0d want 0", a_err); end
        nvec++; if (a_fail !== 1'b0) begin nerr++; $display("FAIL rst_fail got %0d want 0", a_fail); end
        nvec++; if (a_chk !== 16'd0) begin nerr++; $display("FAIL rst_chk got %0d want 0", a_chk); end
        nvec++; if (a_errc !== 16'd0) begin nerr++; $display("FAIL rst_errc got %0d want 0", a_errc); end
        nvec++; if (a_first !== 16'd0) begin nerr++; $display("FAIL rst_first got %0d want 0", a_first); end
        idle(4);
    endtask

    task automatic test_ideal;
        q_mode = 0;
        for (int k = 0; k <= 300; k++) drive(k, k == 0, k == 300);
        nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL ideal_busy got %0d want 0", a_busy); end
        nvec++; if (a_chk !== 16'(300 - 1 - S)) begin nerr++; $display("FAIL ideal_chk got %0d want %0d", a_chk, 300 - 1 - S); end
        nvec++; if (a_errc !== 16'd0) begin nerr++; $display("FAIL ideal_errc got %0d want 0", a_errc); end
        nvec++; if (a_fail !== 1'b0) begin nerr++; $display("FAIL ideal_fail got %0d want 0", a_fail); end
        idle(6);
        nvec++; if (a_chk !== 16'(300 - 1 - S)) begin nerr++; $display("FAIL freeze_chk got %0d want %0d", a_chk, 300 - 1 - S); end
        nvec++; if (a_err !== 1'b0) begin nerr++; $display("FAIL freeze_err got %0d want 0", a_err); end
    endtask

    task automatic test_stuck0;
        q_mode = 1;
        for (int k = 0; k <= 8; k++) begin
            drive(k, k == 0, 1'b0);
            if (k == 7) begin
                nvec++; if (a_err !== 1'b0) begin nerr++; $display("FAIL s0_err7 got %0d want 0", a_err); end
                nvec++; if (a_fail !== 1'b0) begin nerr++; $display("FAIL s0_fail7 got %0d want 0", a_fail); end
                nvec++; if (a_chk !== 16'd5) begin nerr++; $display("FAIL s0_chk7 got %0d want 5", a_chk); end
            end
        end
        nvec++; if (a_err !== 1'b1) begin nerr++; $display("FAIL s0_err8 got %0d want 1", a_err); end
        nvec++; if (a_fail !== 1'b1) begin nerr++; $display("FAIL s0_fail8 got %0d want 1", a_fail); end
        nvec++; if (a_first !== 16'd5) begin nerr++; $display("FAIL s0_first got %0d want 5", a_first); end
        nvec++; if (a_errc !== 16'd1) begin nerr++; $display("FAIL s0_errc got %0d want 1", a_errc); end
        nvec++; if (a_chk !== 16'd6) begin nerr++; $display("FAIL s0_chk8 got %0d want 6", a_chk); end
        drive(9, 1'b0, 1'b1);
        idle(6);
    endtask

    task automatic test_pls_vs_nls;
        q_mode = 0;
        for (int k = 0; k <= 300; k++) drive(k, k == 0, k == 300);
        nvec++; if (p_errc === 16'd0) begin nerr++; $display("FAIL pls_errc got %0d want >0", p_errc); end
        nvec++; if (p_fail !== 1'b1) begin nerr++; $display("FAIL pls_fail got %0d want 1", p_fail); end
        nvec++; if (p_chk !== 16'(300 - 1 - S)) begin nerr++; $display("FAIL pls_chk got %0d want %0d", p_chk, 300 - 1 - S); end
        nvec++; if (a_errc !== 16'd0) begin nerr++; $display("FAIL pls_ref_errc got %0d want 0", a_errc); end
        idle(6);
    endtask

    task automatic test_saturate;
        q_mode = 2;
        for (int k = 0; k <= 40; k++) drive(k, k == 0, 1'b0);
        nvec++; if (c_chk !== 4'd15) begin nerr++; $display("FAIL sat_chk got %0d want 15", c_chk); end
        nvec++; if (c_errc !== 4'd15) begin nerr++; $display("FAIL sat_errc got %0d want 15", c_errc); end
        nvec++; if (c_first !== 4'd0) begin nerr++; $display("FAIL sat_first got %0d want 0", c_first); end
        nvec++; if (c_fail !== 1'b1) begin nerr++; $display("FAIL sat_fail got %0d want 1", c_fail); end
        drive(41, 1'b0, 1'b1);
        idle(6);
    endtask

    task automatic test_mid_reset;
        q_mode = 1;
        for (int k = 0; k <= 21; k++) begin
            rst_in = (k == 20);
            drive(k, k == 0, 1'b0);
            if (k == 19) begin
                nvec++; if (a_fail !== 1'b1) begin nerr++; $display("FAIL mr_fail19 got %0d want 1", a_fail); end
            end
            if (k == 20) begin
                nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL mr_busy got %0d want 0", a_busy); end
                nvec++; if (a_fail !== 1'b0) begin nerr++; $display("FAIL mr_fail got %0d want 0", a_fail); end
                nvec++; if (a_err !== 1'b0) begin nerr++; $display("FAIL mr_err got %0d want 0", a_err); end
                nvec++; if (a_chk !== 16'd0) begin nerr++; $display("FAIL mr_chk got %0d want 0", a_chk); end
                nvec++; if (a_errc !== 16'd0) begin nerr++; $display("FAIL mr_errc got %0d want 0", a_errc); end
                nvec++; if (a_first !== 16'd0) begin nerr++; $display("FAIL mr_first got %0d want 0", a_first); end
            end
        end
        nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL mr_busy21 got %0d want 0", a_busy); end
        idle(6);
    endtask

    task automatic test_restart;
        q_mode = 1;
        for (int k = 0; k <= 24; k++) begin
            drive(k, (k == 0) || (k == 20), k == 24);
            case (k)
                19: begin
                    nvec++; if (a_fail !== 1'b1) begin nerr++; $display("FAIL rs_fail19 got %0d want 1", a_fail); end
                end
                20: begin
                    nvec++; if (a_busy !== 1'b1) begin nerr++; $display("FAIL rs_busy20 got %0d want 1", a_busy); end
                    nvec++; if (a_fail !== 1'b0) begin nerr++; $display("FAIL rs_fail20 got %0d want 0", a_fail); end
                    nvec++; if (a_chk !== 16'd0) begin nerr++; $display("FAIL rs_chk20 got %0d want 0", a_chk); end
                    nvec++; if (a_errc !== 16'd0) begin nerr++; $display("FAIL rs_errc20 got %0d want 0", a_errc); end
                    nvec++; if (a_err !== 1'b0) begin nerr++; $display("FAIL rs_err20 got %0d want 0", a_err); end
                end
                22: begin
                    nvec++; if (a_chk !== 16'd0) begin nerr++; $display("FAIL rs_chk22 got %0d want 0", a_chk); end
                    nvec++; if (a_busy !== 1'b1) begin nerr++; $display("FAIL rs_busy22 got %0d want 1", a_busy); end
                end
                23: begin
                    nvec++; if (a_chk !== 16'd1) begin nerr++; $display("FAIL rs_chk23 got %0d want 1", a_chk); end
                    nvec++; if (a_err !== 1'b1) begin nerr++; $display("FAIL rs_err23 got %0d want 1", a_err); end
                    nvec++; if (a_first !== 16'd0) begin nerr++; $display("FAIL rs_first23 got %0d want 0", a_first); end
                end
                default: ;
            endcase
        end
        nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL rs_busy24 got %0d want 0", a_busy); end
        idle(6);
    endtask

    task automatic test_start_stop_idle;
        q_mode = 0;
        drive(0, 1'b1, 1'b1);
        nvec++; if (a_busy !== 1'b1) begin nerr++; $display("FAIL ss_busy got %0d want 1", a_busy); end
        drive(1, 1'b0, 1'b1);
        nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL ss_stop got %0d want 0", a_busy); end
        idle(4);
    endtask

    initial begin
        #1;
        test_reset;
        test_ideal;
        test_stuck0;
        test_pls_vs_nls;
        test_saturate;
        test_mid_reset;
        test_restart;
        test_start_stop_idle;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
